opcode_encoder: RTL and testbench
=================================

OPCODE_ENCODER -- requirements
Module: opcode_encoder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low: i_clk, i_rst_n.
REQ-002 i_clk  input  1  sole clock, all state on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_valid  input  1  instruction request valid.
REQ-005 o_ready  output  1  encoder can accept a request.
REQ-006 i_mnem  input  6  mnemonic code: alphabetical index of the 56 official NMOS mnemonics, ADC=0 ... TYA=55 (e.g. ASL=2, BRK=10, JMP=27, JSR=28, LDA=29, STA=47, STX=48).
REQ-007 i_mode  input  4  addressing mode: IMP=0 ACC=1 IMM=2 ZPG=3 ZPX=4 ZPY=5 ABS=6 ABX=7 ABY=8 IND=9 XIN=10 INY=11 REL=12.
REQ-008 i_operand  input  16  operand value; REL takes signed offset in [7:0].
REQ-009 o_byte  output  8  instruction byte stream, little-endian operands.
REQ-010 o_byte_valid  output  1  o_byte valid.
REQ-011 i_byte_ready  input  1  sink accepts o_byte.
REQ-012 o_first  output  1  current byte is the opcode byte.
REQ-013 o_last  output  1  current byte is the final byte of the instruction.
REQ-014 o_err  output  1  one-cycle pulse: request was illegal and dropped.

Function
REQ-015 Encoding SHALL follow the official NMOS 6502 opcode map (151 opcodes); any mnemonic/mode pair not in that map, i_mnem>55, or i_mode>12 is illegal.
REQ-016 Request accepted on rising edge with i_valid && o_ready; opcode, length, operand latched that edge.
REQ-017 Length: IMP, ACC = 1; IMM, ZPG, ZPX, ZPY, XIN, INY, REL = 2; ABS, ABX, ABY, IND = 3; BRK (IMP) = 2, second byte i_operand[7:0].
REQ-018 JSR legal only with ABS; JMP legal only with ABS, IND; branches legal only with REL.
REQ-019 FSM states IDLE, OPC, LO, HI, ERR; o_ready=1 only in IDLE.
REQ-020 IDLE: on legal accept -> OPC; on illegal accept -> ERR.
REQ-021 ERR: o_err=1, o_byte_valid=0 for exactly one cycle, then IDLE.
REQ-022 OPC: o_byte=opcode, o_first=1; on byte handshake -> LO if length>=2, else IDLE.
REQ-023 LO: o_byte=operand[7:0]; on handshake -> HI if length=3, else IDLE.
REQ-024 HI: o_byte=operand[15:8]; on handshake -> IDLE.
REQ-025 o_byte_valid=1 in OPC, LO, HI; first byte valid the cycle after accept.
REQ-026 o_last=1 on the byte whose state is final for the latched length (OPC for len 1, LO for len 2, HI for len 3).
REQ-027 Backpressure: while o_byte_valid && !i_byte_ready, o_byte, o_first, o_last held stable, state unchanged, indefinitely.
REQ-028 Byte handshake = o_byte_valid && i_byte_ready on rising edge; one byte per handshake max.
REQ-029 After final handshake o_ready reasserts next cycle; no accept in same cycle as last byte handshake.
REQ-030 Input changes while o_ready=0 SHALL NOT affect the stream in flight.
REQ-031 Opcode lookup combinational from i_mnem/i_mode, registered at accept; no combinational path from inputs to o_byte.

Reset
REQ-032 While i_rst_n=0: state IDLE, o_ready=0, o_byte=8'h00, o_byte_valid=0, o_first=0, o_last=0, o_err=0.
REQ-033 o_ready=1 from first rising edge after i_rst_n deasserts.
REQ-034 Reset asserted mid-instruction abandons remaining bytes immediately; no resumption after release.

Verification
REQ-035 LDA(29) IMM, operand 16'h0042, sink always ready -> bytes A9(first), 42(last); o_ready back next cycle.
REQ-036 STA(47) ABX, operand 16'h1234 -> 9D, 34, 12; o_last only on 12.
REQ-037 ASL(2) ACC -> single byte 0A with o_first=o_last=1; JMP(27) IND 16'hFFFC -> 6C, FC, FF.
REQ-038 STX(48) ABX and i_mnem=60 -> o_err pulse one cycle each, no o_byte_valid, o_ready back after ERR.
REQ-039 JSR(28) ABS 16'hC000 with i_byte_ready low 5 cycles per byte -> 20, 00, C0, each held stable through stall; reset pulled low during byte 00 -> all outputs 0, stream dropped.

Source files
------------

// File: rtl/opcode_encoder.sv
// opcode_encoder: encodes a 6502 mnemonic/mode/operand request into a handshaked
// little-endian instruction byte stream using the official NMOS opcode map.
module opcode_encoder (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [5:0]  i_mnem,
    input  logic [3:0]  i_mode,
    input  logic [15:0] i_operand,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_first,
    output logic        o_last,
    output logic        o_err
);
    typedef enum logic [2:0] {IDLE, OPC, LO, HI, ERR} state_t;

    localparam logic [3:0] IMP = 4'd0, ACC = 4'd1, IMM = 4'd2, ZPG = 4'd3, ZPX = 4'd4, ZPY = 4'd5,
                           ABS = 4'd6, ABX = 4'd7, ABY = 4'd8, IND = 4'd9, XIN = 4'd10, INY = 4'd11,
                           REL = 4'd12;
    localparam logic [15:0] M_IMP = 16'h1 << IMP, M_ACC = 16'h1 << ACC, M_IMM = 16'h1 << IMM,
                            M_ZPG = 16'h1 << ZPG, M_ZPX = 16'h1 << ZPX, M_ZPY = 16'h1 << ZPY,
                            M_ABS = 16'h1 << ABS, M_ABX = 16'h1 << ABX, M_ABY = 16'h1 << ABY,
                            M_IND = 16'h1 << IND, M_XIN = 16'h1 << XIN, M_INY = 16'h1 << INY,
                            M_REL = 16'h1 << REL;
    localparam logic [15:0] M_G1 = M_IMM | M_ZPG | M_ZPX | M_ABS | M_ABX | M_ABY | M_XIN | M_INY;
    localparam logic [15:0] M_SH = M_ACC | M_ZPG | M_ZPX | M_ABS | M_ABX;
    localparam logic [15:0] M_ID = M_ZPG | M_ZPX | M_ABS | M_ABX;
    localparam logic [1:0]  K_FIX = 2'd0, K_G1 = 2'd1, K_G2 = 2'd2;

    // Returns {legal, opcode}; grouped opcodes are base | bbb<<2 with bbb picked by mode.
    function automatic logic [8:0] lookup(input logic [5:0] m, input logic [3:0] md);
        logic [1:0]  kind;
        logic [7:0]  base;
        logic [15:0] msk;
        logic [2:0]  b1, b2;
        {kind, base, msk} = {K_FIX, 8'h00, 16'h0000};
        case (m)
            6'd0:  {kind, base, msk} = {K_G1, 8'h61, M_G1};
            6'd1:  {kind, base, msk} = {K_G1, 8'h21, M_G1};
            6'd2:  {kind, base, msk} = {K_G2, 8'h02, M_SH};
            6'd3:  {kind, base, msk} = {K_FIX, 8'h90, M_REL};
            6'd4:  {kind, base, msk} = {K_FIX, 8'hB0, M_REL};
            6'd5:  {kind, base, msk} = {K_FIX, 8'hF0, M_REL};
            6'd6:  {kind, base, msk} = {K_G2, 8'h20, M_ZPG | M_ABS};
            6'd7:  {kind, base, msk} = {K_FIX, 8'h30, M_REL};
            6'd8:  {kind, base, msk} = {K_FIX, 8'hD0, M_REL};
            6'd9:  {kind, base, msk} = {K_FIX, 8'h10, M_REL};
            6'd10: {kind, base, msk} = {K_FIX, 8'h00, M_IMP};
            6'd11: {kind, base, msk} = {K_FIX, 8'h50, M_REL};
            6'd12: {kind, base, msk} = {K_FIX, 8'h70, M_REL};
            6'd13: {kind, base, msk} = {K_FIX, 8'h18, M_IMP};
            6'd14: {kind, base, msk} = {K_FIX, 8'hD8, M_IMP};
            6'd15: {kind, base, msk} = {K_FIX, 8'h58, M_IMP};
            6'd16: {kind, base, msk} = {K_FIX, 8'hB8, M_IMP};
            6'd17: {kind, base, msk} = {K_G1, 8'hC1, M_G1};
            6'd18: {kind, base, msk} = {K_G2, 8'hE0, M_IMM | M_ZPG | M_ABS};
            6'd19: {kind, base, msk} = {K_G2, 8'hC0, M_IMM | M_ZPG | M_ABS};
            6'd20: {kind, base, msk} = {K_G2, 8'hC2, M_ID};
            6'd21: {kind, base, msk} = {K_FIX, 8'hCA, M_IMP};
            6'd22: {kind, base, msk} = {K_FIX, 8'h88, M_IMP};
            6'd23: {kind, base, msk} = {K_G1, 8'h41, M_G1};
            6'd24: {kind, base, msk} = {K_G2, 8'hE2, M_ID};
            6'd25: {kind, base, msk} = {K_FIX, 8'hE8, M_IMP};
            6'd26: {kind, base, msk} = {K_FIX, 8'hC8, M_IMP};
            6'd27: {kind, base, msk} = {K_FIX, md == IND ? 8'h6C : 8'h4C, M_ABS | M_IND};
            6'd28: {kind, base, msk} = {K_FIX, 8'h20, M_ABS};
            6'd29: {kind, base, msk} = {K_G1, 8'hA1, M_G1};
            6'd30: {kind, base, msk} = {K_G2, 8'hA2, M_IMM | M_ZPG | M_ZPY | M_ABS | M_ABY};
            6'd31: {kind, base, msk} = {K_G2, 8'hA0, M_IMM | M_ZPG | M_ZPX | M_ABS | M_ABX};
            6'd32: {kind, base, msk} = {K_G2, 8'h42, M_SH};
            6'd33: {kind, base, msk} = {K_FIX, 8'hEA, M_IMP};
            6'd34: {kind, base, msk} = {K_G1, 8'h01, M_G1};
            6'd35: {kind, base, msk} = {K_FIX, 8'h48, M_IMP};
            6'd36: {kind, base, msk} = {K_FIX, 8'h08, M_IMP};
            6'd37: {kind, base, msk} = {K_FIX, 8'h68, M_IMP};
            6'd38: {kind, base, msk} = {K_FIX, 8'h28, M_IMP};
            6'd39: {kind, base, msk} = {K_G2, 8'h22, M_SH};
            6'd40: {kind, base, msk} = {K_G2, 8'h62, M_SH};
            6'd41: {kind, base, msk} = {K_FIX, 8'h40, M_IMP};
            6'd42: {kind, base, msk} = {K_FIX, 8'h60, M_IMP};
            6'd43: {kind, base, msk} = {K_G1, 8'hE1, M_G1};
            6'd44: {kind, base, msk} = {K_FIX, 8'h38, M_IMP};
            6'd45: {kind, base, msk} = {K_FIX, 8'hF8, M_IMP};
            6'd46: {kind, base, msk} = {K_FIX, 8'h78, M_IMP};
            6'd47: {kind, base, msk} = {K_G1, 8'h81, M_G1 & ~M_IMM};
            6'd48: {kind, base, msk} = {K_G2, 8'h82, M_ZPG | M_ZPY | M_ABS};
            6'd49: {kind, base, msk} = {K_G2, 8'h80, M_ZPG | M_ZPX | M_ABS};
            6'd50: {kind, base, msk} = {K_FIX, 8'hAA, M_IMP};
            6'd51: {kind, base, msk} = {K_FIX, 8'hA8, M_IMP};
            6'd52: {kind, base, msk} = {K_FIX, 8'hBA, M_IMP};
            6'd53: {kind, base, msk} = {K_FIX, 8'h8A, M_IMP};
            6'd54: {kind, base, msk} = {K_FIX, 8'h9A, M_IMP};
            6'd55: {kind, base, msk} = {K_FIX, 8'h98, M_IMP};
            default: {kind, base, msk} = {K_FIX, 8'h00, 16'h0000};
        endcase
        b1 = 3'd0;
        case (md)
            XIN: b1 = 3'd0;
            ZPG: b1 = 3'd1;
            IMM: b1 = 3'd2;
            ABS: b1 = 3'd3;
            INY: b1 = 3'd4;
            ZPX: b1 = 3'd5;
            ABY: b1 = 3'd6;
            ABX: b1 = 3'd7;
            default: b1 = 3'd0;
        endcase
        b2 = 3'd0;
        case (md)
            IMM: b2 = 3'd0;
            ZPG: b2 = 3'd1;
            ACC: b2 = 3'd2;
            ABS: b2 = 3'd3;
            ZPX, ZPY: b2 = 3'd5;
            ABX, ABY: b2 = 3'd7;
            default: b2 = 3'd0;
        endcase
        return {msk[md], kind == K_G1 ? base | {3'b000, b1, 2'b00} :
                         kind == K_G2 ? base | {3'b000, b2, 2'b00} : base};
    endfunction

    state_t      state_q, state_d;
    logic        rdy_q;
    logic [7:0]  op_q, op_d;
    logic [1:0]  len_q, len_d;
    logic [15:0] opnd_q, opnd_d;
    logic [8:0]  lkp;
    logic [1:0]  len;
    logic        hs;

    assign lkp = lookup(i_mnem, i_mode);
    assign len = (i_mnem == 6'd10) ? 2'd2 :
                 (i_mode == IMP || i_mode == ACC) ? 2'd1 :
                 (i_mode == ABS || i_mode == ABX || i_mode == ABY || i_mode == IND) ? 2'd3 : 2'd2;

    assign o_ready      = rdy_q && state_q == IDLE;
    assign o_byte_valid = state_q == OPC || state_q == LO || state_q == HI;
    assign o_byte       = state_q == OPC ? op_q : state_q == LO ? opnd_q[7:0] :
                          state_q == HI ? opnd_q[15:8] : 8'h00;
    assign o_first      = state_q == OPC;
    assign o_last       = (state_q == OPC && len_q == 2'd1) || (state_q == LO && len_q == 2'd2) ||
                          state_q == HI;
    assign o_err        = state_q == ERR;
    assign hs           = o_byte_valid && i_byte_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            op_q    <= 8'h00;
            len_q   <= 2'd0;
            opnd_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            op_q    <= op_d;
            len_q   <= len_d;
            opnd_q  <= opnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        opnd_d  = opnd_q;
        case (state_q)
            IDLE: if (i_valid && o_ready) begin
                state_d = lkp[8] ? OPC : ERR;
                op_d    = lkp[7:0];
                len_d   = len;
                opnd_d  = i_operand;
            end
            OPC: if (hs) state_d = len_q == 2'd1 ? IDLE : LO;
            LO:  if (hs) state_d = len_q == 2'd3 ? HI : IDLE;
            HI:  if (hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_opcode_encoder.sv
// tb_opcode_encoder: table-driven requests with a byte scoreboard, backpressure
// stability monitor, stalled JSR and mid-instruction reset sequences.
module tb_opcode_encoder;
    typedef struct {
        logic [5:0]  mnem;
        logic [3:0]  mode;
        logic [15:0] opnd;
        logic        err;
        logic [1:0]  len;
        logic [7:0]  op;
    } vec_t;
    typedef struct packed {
        logic [7:0] b;
        logic       f;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst_n, i_valid, i_byte_ready;
    logic [5:0]  i_mnem;
    logic [3:0]  i_mode;
    logic [15:0] i_operand;
    logic        o_ready, o_byte_valid, o_first, o_last, o_err;
    logic [7:0]  o_byte;

    int   checks = 0, errors = 0;
    int   rdy_mode = 0;
    exp_t sb[$];
    exp_t e;
    vec_t vt[24];
    logic [7:0] pb;
    logic pf, pl, pstall = 1'b0;

    opcode_encoder dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_mnem(i_mnem), .i_mode(i_mode), .i_operand(i_operand),
        .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
        .o_first(o_first), .o_last(o_last), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) if (rdy_mode == 1) begin
        #1;
        i_byte_ready = 1'($urandom_range(0, 1));
    end

    // Byte scoreboard and hold-under-backpressure check, sampled mid-cycle.
    always @(negedge clk) begin
        if (i_rst_n && pstall)
            chk("stall_hold", {o_byte_valid, o_byte, o_first, o_last}, {1'b1, pb, pf, pl});
        if (i_rst_n && o_byte_valid && i_byte_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h, expected no byte", o_byte);
            end else begin
                e = sb.pop_front();
                chk("byte", {o_byte, o_first, o_last}, {e.b, e.f, e.l});
            end
        end
        pstall = i_rst_n && o_byte_valid && !i_byte_ready;
        {pb, pf, pl} = {o_byte, o_first, o_last};
    end

    task automatic send(input vec_t v, input int stall);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", o_ready, 1);
        {i_mnem, i_mode, i_operand, i_valid} = {v.mnem, v.mode, v.opnd, 1'b1};
        if (stall > 0) i_byte_ready = 1'b0;
        if (!v.err) begin
            sb.push_back('{v.op, 1'b1, v.len == 2'd1});
            if (v.len >= 2'd2) sb.push_back('{v.opnd[7:0], 1'b0, v.len == 2'd2});
            if (v.len == 2'd3) sb.push_back('{v.opnd[15:8], 1'b0, 1'b1});
        end
        @(posedge clk); #1;
        i_valid   = 1'b0;
        i_mnem    = 6'($urandom);
        i_mode    = 4'($urandom);
        i_operand = 16'($urandom);
        if (v.err) begin
            chk("err_pulse", {o_err, o_byte_valid, o_ready}, 3'b100);
            @(posedge clk); #1;
            chk("err_done", {o_err, o_byte_valid, o_ready}, 3'b001);
        end else begin
            chk("first_valid", {o_byte_valid, o_first, o_ready}, 3'b110);
            n = 0;
            while (sb.size() > 0 && n < 200) begin
                if (stall > 0) i_byte_ready = (n % (stall + 1)) == stall;
                @(posedge clk); #1; n++;
            end
            chk("drain", sb.size(), 0);
            chk("ready_back", {o_ready, o_byte_valid}, 2'b10);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{6'd29, 4'd2,  16'h0042, 1'b0, 2'd2, 8'hA9};
        vt[1]  = '{6'd47, 4'd7,  16'h1234, 1'b0, 2'd3, 8'h9D};
        vt[2]  = '{6'd2,  4'd1,  16'h0000, 1'b0, 2'd1, 8'h0A};
        vt[3]  = '{6'd27, 4'd9,  16'hFFFC, 1'b0, 2'd3, 8'h6C};
        vt[4]  = '{6'd48, 4'd7,  16'h0000, 1'b1, 2'd0, 8'h00};
        vt[5]  = '{6'd60, 4'd0,  16'h0000, 1'b1, 2'd0, 8'h00};
        vt[6]  = '{6'd10, 4'd0,  16'h0055, 1'b0, 2'd2, 8'h00};
        vt[7]  = '{6'd8,  4'd12, 16'h00FE, 1'b0, 2'd2, 8'hD0};
        vt[8]  = '{6'd30, 4'd8,  16'h3456, 1'b0, 2'd3, 8'hBE};
        vt[9]  = '{6'd24, 4'd4,  16'h0010, 1'b0, 2'd2, 8'hF6};
        vt[10] = '{6'd34, 4'd10, 16'h0020, 1'b0, 2'd2, 8'h01};
        vt[11] = '{6'd43, 4'd11, 16'h0030, 1'b0, 2'd2, 8'hF1};
        vt[12] = '{6'd55, 4'd0,  16'h0000, 1'b0, 2'd1, 8'h98};
        vt[13] = '{6'd18, 4'd6,  16'h2000, 1'b0, 2'd3, 8'hEC};
        vt[14] = '{6'd31, 4'd7,  16'h1111, 1'b0, 2'd3, 8'hBC};
        vt[15] = '{6'd40, 4'd7,  16'hABCD, 1'b0, 2'd3, 8'h7E};
        vt[16] = '{6'd27, 4'd7,  16'h0000, 1'b1, 2'd0, 8'h00};
        vt[17] = '{6'd8,  4'd2,  16'h0000, 1'b1, 2'd0, 8'h00};
        vt[18] = '{6'd29, 4'd13, 16'h0000, 1'b1, 2'd0, 8'h00};
        vt[19] = '{6'd47, 4'd2,  16'h0000, 1'b1, 2'd0, 8'h00};
        vt[20] = '{6'd49, 4'd5,  16'h0000, 1'b1, 2'd0, 8'h00};
        vt[21] = '{6'd28, 4'd6,  16'hC000, 1'b0, 2'd3, 8'h20};
        vt[22] = '{6'd27, 4'd6,  16'h8000, 1'b0, 2'd3, 8'h4C};
        vt[23] = '{6'd21, 4'd0,  16'h0000, 1'b0, 2'd1, 8'hCA};

        {i_rst_n, i_valid, i_byte_ready, i_mnem, i_mode, i_operand} = '0;
        #2;
        chk("reset_outputs", {o_ready, o_byte, o_byte_valid, o_first, o_last, o_err}, 13'h0);
        @(posedge clk); @(posedge clk); #1;
        i_rst_n = 1'b1;
        i_byte_ready = 1'b1;
        chk("ready_before_edge", o_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_release", {o_ready, o_byte_valid}, 2'b10);

        for (int i = 0; i < 24; i++) send(vt[i], 0);
        rdy_mode = 1;
        for (int i = 0; i < 24; i++) send(vt[i], 0);
        @(posedge clk); #1;
        rdy_mode = 2;
        send(vt[21], 5);

        // JSR again, reset pulled during the stalled 00 operand byte.
        i_byte_ready = 1'b0;
        {i_mnem, i_mode, i_operand, i_valid} = {6'd28, 4'd6, 16'hC000, 1'b1};
        sb.push_back('{8'h20, 1'b1, 1'b0});
        sb.push_back('{8'h00, 1'b0, 1'b0});
        sb.push_back('{8'hC0, 1'b0, 1'b1});
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("jsr_held_opc", {o_byte_valid, o_byte, o_first}, {1'b1, 8'h20, 1'b1});
        i_byte_ready = 1'b1;
        @(posedge clk); #1;
        i_byte_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("jsr_lo_stalled", {o_byte_valid, o_byte, o_last}, {1'b1, 8'h00, 1'b0});
        i_rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {o_ready, o_byte, o_byte_valid, o_first, o_last, o_err}, 13'h0);
        sb.delete();
        @(posedge clk); @(posedge clk); #1;
        i_rst_n = 1'b1;
        i_byte_ready = 1'b1;
        rdy_mode = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_resume", {o_ready, o_byte_valid}, 2'b10);
        end
        send(vt[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
